// File: rtl/collision_pkg.sv
// Shared event types, wall codes and lowest/second-lowest bit selection helpers
// for collision_manager and its event FIFO.
package collision_pkg;

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        EVT_WALL = 2'b01,
        EVT_HOLE = 2'b10,
        EVT_BALL = 2'b11
    } evt_type_t;

    localparam logic [1:0] WALL_NONE   = 2'b00;
    localparam logic [1:0] WALL_TOP    = 2'b01;
    localparam logic [1:0] WALL_SIDE   = 2'b10;
    localparam logic [1:0] WALL_CORNER = 2'b11;

    localparam int MAX_BALLS = 32;
    localparam int MAX_ID_W  = 5;

    typedef logic [MAX_BALLS-1:0] ball_vec_t;
    typedef logic [MAX_ID_W-1:0]  ball_id_t;

    typedef struct packed {
        evt_type_t  etype;
        ball_id_t   id_a;
        ball_id_t   id_b;
        logic [2:0] info;
    } event_t;

    function automatic ball_id_t lowest_idx(input ball_vec_t v);
        ball_id_t idx;
        idx = '0;
        for (int i = MAX_BALLS - 1; i >= 0; i--)
            if (v[i]) idx = ball_id_t'(i);
        return idx;
    endfunction

    function automatic ball_vec_t clear_lowest(input ball_vec_t v);
        return v & (v - ball_vec_t'(1));
    endfunction

    function automatic ball_id_t second_idx(input ball_vec_t v);
        return lowest_idx(clear_lowest(v));
    endfunction

    function automatic logic two_or_more(input ball_vec_t v);
        return clear_lowest(v) != '0;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Showahead event FIFO with full/empty flags; a push while full is accepted
// only when a pop happens in the same cycle, otherwise it is reported as a drop.
module event_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW-1:0]               r_wr;
    logic [AW-1:0]               r_rd;
    logic [AW:0]                 r_cnt;
    logic                        w_pop;
    logic                        w_push;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && !w_push;
    assign o_rdata = r_mem[r_rd];

    // Storage is reset so the head reads all zeros straight out of reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_mem <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/collision_manager.sv
// Pixel-level wall/hole/ball overlap detection with per-ball hold-off, feeding an event FIFO.
// Define COLLISION_DROP_CNT_EN to add drop_cnt, a saturating 8-bit count of dropped events.
module collision_manager
    import collision_pkg::*;
#(
    parameter int NUM_BALLS      = 16,
    parameter int ID_W           = $clog2(NUM_BALLS),
    parameter int HOLDOFF_FRAMES = 2,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [1:0]           Table_DR,
    input  logic [NUM_BALLS-1:0] Balls_DR_VEC,
    input  logic                 Hole_DR,
    input  logic [2:0]           Hole_ID,
    output logic                 collision,
    output logic [NUM_BALLS-1:0] balls_in_game,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [1:0]           evt_type,
    output logic [ID_W-1:0]      evt_id_a,
    output logic [ID_W-1:0]      evt_id_b,
    output logic [2:0]           evt_info
`ifdef COLLISION_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    localparam int         EVT_W     = 2 + 2 * ID_W + 3;
    localparam logic [2:0] HOLD_LOAD = 3'(HOLDOFF_FRAMES);

    logic [NUM_BALLS-1:0]      r_in_game;
    logic [NUM_BALLS-1:0][2:0] r_hold_ball;
    logic [NUM_BALLS-1:0][2:0] r_hold_wall;
    event_t                    r_stage;
    logic                      r_stage_vld;

    logic [NUM_BALLS-1:0] w_act;
    logic [NUM_BALLS-1:0] w_ball_mute;
    logic [NUM_BALLS-1:0] w_wall_mute;
    logic [NUM_BALLS-1:0] w_stage_a;
    logic [NUM_BALLS-1:0] w_stage_ab;
    logic [NUM_BALLS-1:0] w_ball_elig;
    logic [NUM_BALLS-1:0] w_wall_elig;
    logic [NUM_BALLS-1:0] w_arm_ball;
    logic [NUM_BALLS-1:0] w_arm_wall;
    logic [NUM_BALLS-1:0] w_hole_clr;
    logic                 w_hole_raw;
    logic                 w_ball_raw;
    logic                 w_wall_raw;
    event_t               w_sel;
    logic                 w_sel_vld;
    logic [EVT_W-1:0]     w_wdata;
    logic [EVT_W-1:0]     w_rdata;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_empty;
    logic                 w_unused_full;

    assign w_act      = Balls_DR_VEC & r_in_game;
    assign w_hole_raw = Hole_DR && (w_act != '0);
    assign w_ball_raw = two_or_more(ball_vec_t'(w_act));
    assign w_wall_raw = (Table_DR != WALL_NONE) && (w_act != '0);
    assign collision  = w_hole_raw || w_ball_raw || w_wall_raw;

    always_comb begin
        w_ball_mute = '0;
        w_wall_mute = '0;
        w_stage_a   = '0;
        w_stage_ab  = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            w_ball_mute[i] = (r_hold_ball[i] != 3'd0);
            w_wall_mute[i] = (r_hold_wall[i] != 3'd0);
            w_stage_a[i]   = r_stage_vld && (r_stage.id_a == ball_id_t'(i));
            w_stage_ab[i]  = w_stage_a[i] || (r_stage_vld && (r_stage.id_b == ball_id_t'(i)));
        end
    end

    // Balls still in the stage register count as muted so a back-to-back pixel never double-reports.
    assign w_ball_elig = w_act & ~w_ball_mute & ~((r_stage.etype == EVT_BALL) ? w_stage_ab : '0);
    assign w_wall_elig = w_act & ~w_wall_mute & ~((r_stage.etype == EVT_WALL) ? w_stage_a : '0);

    always_comb begin
        w_sel = '0;
        if (w_hole_raw) begin
            w_sel.etype = EVT_HOLE;
            w_sel.id_a  = lowest_idx(ball_vec_t'(w_act));
            w_sel.info  = Hole_ID;
        end else if (two_or_more(ball_vec_t'(w_ball_elig))) begin
            w_sel.etype = EVT_BALL;
            w_sel.id_a  = lowest_idx(ball_vec_t'(w_ball_elig));
            w_sel.id_b  = second_idx(ball_vec_t'(w_ball_elig));
        end else if (w_wall_raw && (w_wall_elig != '0)) begin
            w_sel.etype = EVT_WALL;
            w_sel.id_a  = lowest_idx(ball_vec_t'(w_wall_elig));
            w_sel.info  = {1'b0, Table_DR};
        end
    end

    assign w_sel_vld = (w_sel.etype != EVT_NONE);

    always_comb begin
        w_arm_ball = '0;
        w_arm_wall = '0;
        w_hole_clr = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            w_arm_ball[i] = (w_sel.etype == EVT_BALL) &&
                            ((w_sel.id_a == ball_id_t'(i)) || (w_sel.id_b == ball_id_t'(i)));
            w_arm_wall[i] = (w_sel.etype == EVT_WALL) && (w_sel.id_a == ball_id_t'(i));
            w_hole_clr[i] = (w_sel.etype == EVT_HOLE) && (w_sel.id_a == ball_id_t'(i));
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_in_game   <= '1;
            r_hold_ball <= '0;
            r_hold_wall <= '0;
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
        end else begin
            r_in_game   <= r_in_game & ~w_hole_clr;
            r_stage     <= w_sel;
            r_stage_vld <= w_sel_vld;
            // Arming takes precedence over the frame decrement.
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (w_arm_ball[i])
                    r_hold_ball[i] <= HOLD_LOAD;
                else if (startOfFrame && w_ball_mute[i])
                    r_hold_ball[i] <= r_hold_ball[i] - 3'd1;
                if (w_arm_wall[i])
                    r_hold_wall[i] <= HOLD_LOAD;
                else if (startOfFrame && w_wall_mute[i])
                    r_hold_wall[i] <= r_hold_wall[i] - 3'd1;
            end
        end
    end

    assign balls_in_game = r_in_game;

    assign w_wdata = {r_stage.etype, r_stage.id_a[ID_W-1:0], r_stage.id_b[ID_W-1:0], r_stage.info};
    assign w_pop   = evt_valid && evt_ready;

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .i_push  (r_stage_vld),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_unused_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign evt_valid = !w_empty;
    assign {evt_type, evt_id_a, evt_id_b, evt_info} = w_rdata;

`ifdef COLLISION_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_drop_cnt <= 8'd0;
        else if (w_drop && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_collision_manager.sv
// Directed plus randomized bench for collision_manager against a queue-based event model.
module tb_collision_manager;

    localparam int NB    = 16;
    localparam int IDW   = $clog2(NB);
    localparam int HOLD  = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           resetN;
    logic           startOfFrame;
    logic [1:0]     Table_DR;
    logic [NB-1:0]  Balls_DR_VEC;
    logic           Hole_DR;
    logic [2:0]     Hole_ID;
    logic           collision;
    logic [NB-1:0]  balls_in_game;
    logic           evt_valid;
    logic           evt_ready;
    logic [1:0]     evt_type;
    logic [IDW-1:0] evt_id_a;
    logic [IDW-1:0] evt_id_b;
    logic [2:0]     evt_info;
`ifdef COLLISION_DROP_CNT_EN
    logic [7:0]     drop_cnt;
`endif

    always #5 clk = ~clk;

    collision_manager #(
        .NUM_BALLS(NB), .ID_W(IDW), .HOLDOFF_FRAMES(HOLD), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .Table_DR(Table_DR), .Balls_DR_VEC(Balls_DR_VEC),
        .Hole_DR(Hole_DR), .Hole_ID(Hole_ID),
        .collision(collision), .balls_in_game(balls_in_game),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .evt_id_a(evt_id_a), .evt_id_b(evt_id_b),
        .evt_info(evt_info)
`ifdef COLLISION_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    // Reference model: per-ball mute counters, in-play flags, one-deep stage and the event queue.
    typedef struct {int t; int a; int b; int info;} mevt_t;
    int    hb[NB];
    int    hw[NB];
    bit    ing[NB];
    mevt_t q[$];
    mevt_t st;
    bit    st_v;
    int    drops;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin hb[i] = 0; hw[i] = 0; ing[i] = 1'b1; end
        q.delete();
        st = '{0, 0, 0, 0};
        st_v = 1'b0;
        drops = 0;
    endtask

    function automatic mevt_t pick();
        mevt_t e;
        int act[$];
        int eb[$];
        int ew[$];
        e = '{0, 0, 0, 0};
        for (int i = 0; i < NB; i++)
            if (Balls_DR_VEC[i] === 1'b1 && ing[i]) begin
                act.push_back(i);
                if (hb[i] == 0) eb.push_back(i);
                if (hw[i] == 0) ew.push_back(i);
            end
        if (Hole_DR && act.size() > 0)            e = '{2, act[0], 0, int'(Hole_ID)};
        else if (eb.size() >= 2)                  e = '{3, eb[0], eb[1], 0};
        else if (Table_DR != 2'b00 && ew.size() > 0) e = '{1, ew[0], 0, int'(Table_DR)};
        return e;
    endfunction

    function automatic bit exp_coll();
        int n;
        n = 0;
        for (int i = 0; i < NB; i++) if (Balls_DR_VEC[i] === 1'b1 && ing[i]) n++;
        return (n >= 2) || (n > 0 && (Hole_DR || Table_DR != 2'b00));
    endfunction

    task automatic model_edge();
        mevt_t e;
        e = pick();
        if (q.size() > 0 && evt_ready) q.delete(0);
        if (st_v) begin
            if (q.size() < DEPTH) q.push_back(st);
            else if (drops < 255) drops++;
        end
        st = e;
        st_v = (e.t != 0);
        for (int i = 0; i < NB; i++) begin
            if (startOfFrame && hb[i] > 0) hb[i]--;
            if (startOfFrame && hw[i] > 0) hw[i]--;
        end
        if (e.t == 3) begin hb[e.a] = HOLD; hb[e.b] = HOLD; end
        if (e.t == 1) hw[e.a] = HOLD;
        if (e.t == 2) ing[e.a] = 1'b0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NB-1:0] g;
        for (int i = 0; i < NB; i++) g[i] = ing[i];
        chk("balls_in_game", balls_in_game, g);
        chk("collision", collision, exp_coll());
        chk("evt_valid", evt_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("evt_type", evt_type, q[0].t);
            chk("evt_id_a", evt_id_a, q[0].a);
            chk("evt_id_b", evt_id_b, q[0].b);
            chk("evt_info", evt_info, q[0].info);
        end
`ifdef COLLISION_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, drops);
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr_in();
        Balls_DR_VEC = '0; Table_DR = 2'b00; Hole_DR = 1'b0; Hole_ID = 3'd0;
    endtask

    task automatic px(input logic [NB-1:0] v, input logic [1:0] t, input logic h, input logic [2:0] hid);
        Balls_DR_VEC = v; Table_DR = t; Hole_DR = h; Hole_ID = hid;
        tick();
        clr_in();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            startOfFrame = 1'b1; tick();
            startOfFrame = 1'b0; tick();
        end
    endtask

    task automatic expect_head(string tag, input int t, input int a, input int b, input int info);
        chk({tag, ".valid"}, evt_valid, 1);
        chk({tag, ".type"},  evt_type, t);
        chk({tag, ".id_a"},  evt_id_a, a);
        chk({tag, ".id_b"},  evt_id_b, b);
        chk({tag, ".info"},  evt_info, info);
    endtask

    initial begin
        int wl[10];
        wl = '{0, 1, 3, 4, 5, 6, 8, 9, 10, 11};
        resetN = 1'b0; startOfFrame = 1'b0; evt_ready = 1'b1;
        clr_in();
        model_reset();
        #12;
        chk("rst.valid", evt_valid, 0);
        chk("rst.type", evt_type, 0);
        chk("rst.id_a", evt_id_a, 0);
        chk("rst.id_b", evt_id_b, 0);
        chk("rst.info", evt_info, 0);
        chk("rst.in_game", balls_in_game, 16'hFFFF);
`ifdef COLLISION_DROP_CNT_EN
        chk("rst.drop_cnt", drop_cnt, 0);
`endif
        resetN = 1'b1;

        // Ball pair, muted repeat, then re-armed after two frames.
        px(16'h0003, 2'b00, 1'b0, 3'd0);
        tick();
        expect_head("ball01", 3, 0, 1, 0);
        idle(2);
        px(16'h0003, 2'b00, 1'b0, 3'd0);
        idle(3);
        chk("ball01_muted", evt_valid, 0);
        frames(2);
        px(16'h0003, 2'b00, 1'b0, 3'd0);
        tick();
        expect_head("ball01_again", 3, 0, 1, 0);
        idle(2);

        // Long wall contact reports once.
        Balls_DR_VEC = 16'h0020; Table_DR = 2'b10;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 1) expect_head("wall5", 1, 5, 0, 2);
        end
        clr_in();
        idle(3);
        chk("wall5_once", evt_valid, 0);

        // Hole removes ball 7 for good.
        px(16'h0080, 2'b00, 1'b1, 3'd3);
        tick();
        expect_head("hole7", 2, 7, 0, 3);
        chk("b7_out", balls_in_game[7], 0);
        idle(2);
        Balls_DR_VEC = 16'h0080; Table_DR = 2'b01;
        #1;
        chk("b7_no_coll", collision, 0);
        tick();
        clr_in();
        idle(3);
        chk("b7_no_evt", evt_valid, 0);

        // Hole beats ball overlap in the same pixel; ball 2 then gone.
        px(16'h0014, 2'b00, 1'b1, 3'd5);
        px(16'h0014, 2'b00, 1'b0, 3'd0);
        expect_head("hole2", 2, 2, 0, 5);
        chk("b2_out", balls_in_game[2], 0);
        tick();
        chk("no_ball_after_hole", evt_valid, 0);
        idle(2);

        // Ten walls into a stalled FIFO: first eight kept in order.
        frames(2);
        evt_ready = 1'b0;
        for (int k = 0; k < 10; k++) px(NB'(1) << wl[k], 2'b01, 1'b0, 3'd0);
        idle(3);
`ifdef COLLISION_DROP_CNT_EN
        chk("drop_cnt_2", drop_cnt, 2);
`endif
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_head("drain", 1, wl[k], 0, 1);
            tick();
        end
        chk("drained", evt_valid, 0);

        // Three-way overlap reports lowest two.
        frames(2);
        px(16'h004A, 2'b00, 1'b0, 3'd0);
        tick();
        expect_head("ball13", 3, 1, 3, 0);
        idle(2);

        // Mid-operation reset flushes stage and FIFO.
        evt_ready = 1'b0;
        px(16'h0300, 2'b00, 1'b0, 3'd0);
        px(16'h1000, 2'b11, 1'b0, 3'd0);
        resetN = 1'b0;
        clr_in();
        #2;
        chk("mid_rst.valid", evt_valid, 0);
        chk("mid_rst.in_game", balls_in_game, 16'hFFFF);
        chk("mid_rst.type", evt_type, 0);
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB; i++) Balls_DR_VEC[i] = ($urandom_range(5) == 0);
            Table_DR     = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
            Hole_DR      = ($urandom_range(63) == 0);
            Hole_ID      = 3'($urandom_range(7));
            evt_ready    = ($urandom_range(1) == 1);
            startOfFrame = (c % 16 == 0);
            tick();
        end
        clr_in();
        startOfFrame = 1'b0;
        evt_ready = 1'b1;
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/collision_manager.md
# collision_manager

Parametrised successor to the two-ball game controller: detects ball/wall, ball/hole and ball/ball overlaps for `NUM_BALLS` balls from per-pixel drawing requests. Each event is written to a small event FIFO that the physics/move blocks drain.
- Per-ball, per-type hold-off counters replace the single per-frame flags, so several distinct collisions can be reported in one frame.
- Sits between the VGA object drawers and the ball movement blocks; `balls_in_game` remains the authoritative in-play mask.

## Interface
- `NUM_BALLS`, default 16: number of balls. Index 0 is the white ball. Range 2..32.
- `ID_W`, default `$clog2(NUM_BALLS)`: width of a ball ID.
- `HOLDOFF_FRAMES`, default 2: frames a reported ball stays muted for the same event type. Range 1..7.
- `FIFO_DEPTH`, default 8: event FIFO depth. Must be a power of two.
- `clk` in 1: pixel clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `Table_DR` in 2: wall drawing request. 00 means none; nonzero is the wall code.
- `Balls_DR_VEC` in NUM_BALLS: per-ball drawing request.
- `Hole_DR` in 1: hole drawing request.
- `Hole_ID` in 3: ID of the hole being drawn.
- `collision` out 1: combinational OR of all three raw overlap conditions, on in-game balls only.
- `balls_in_game` out NUM_BALLS: balls still on the table.
- `evt_valid` out 1: FIFO head is valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_type` out 2: 01 WALL, 10 HOLE, 11 BALL.
- `evt_id_a` out ID_W: ball ID.
- `evt_id_b` out ID_W: second ball for BALL events, 0 otherwise.
- `evt_info` out 3: wall code (zero-extended) for WALL, `Hole_ID` for HOLE, 0 for BALL.

## Operation
- Masked vector: `act = Balls_DR_VEC & balls_in_game`.
- Raw conditions:
  - HOLE: `Hole_DR && act!=0`.
  - BALL: `popcount(act)>=2`.
  - WALL: `Table_DR!=0 && act!=0`.
- Eligibility filtering:
  - Balls whose hold-off counter for that type is nonzero are removed before selection.
  - HOLE has no hold-off.
- Selection:
  - A = lowest eligible set bit.
  - BALL additionally takes B = next set bit above A. Both A and B must be eligible.
  - With three or more balls overlapping, only the lowest two are reported.
- Priority: at most one event is accepted per cycle, in the order HOLE > BALL > WALL. Losing events are not armed and re-detect on a later pixel.
- On acceptance:
  - BALL loads `holdoff_ball[A]` and `holdoff_ball[B]` with HOLDOFF_FRAMES.
  - WALL loads `holdoff_wall[A]` with HOLDOFF_FRAMES.
  - HOLE clears `balls_in_game[A]`.
- Hold-off decrement: every counter decrements by one on `startOfFrame`, saturating at 0. If arm and decrement happen in the same cycle, arm wins.
- FIFO full at write:
  - The event is dropped, but hold-off is still armed.
  - `balls_in_game` is still cleared for a dropped HOLE event.
- `balls_in_game` never re-sets except on reset.
- Pop: on `evt_valid && evt_ready`. A push to a full FIFO in the same cycle as a pop succeeds.

## Timing
- Reset values:
  - `balls_in_game` all ones.
  - `evt_valid` 0; `evt_type`, `evt_id_a`, `evt_id_b`, `evt_info` all 0.
  - All hold-off counters 0; FIFO empty.
  - Drop counter 0.
- Pipeline:
  - Cycle t: detection and selection.
  - Edge t+1: stage register; hold-off arm; `balls_in_game` update.
  - Edge t+2: FIFO write.
  - With the FIFO empty, `evt_valid` is high in cycle t+2.
- A second overlap pixel in cycle t+1 must already see the armed hold-off. To achieve this, eligibility also excludes the balls held in a valid stage register.
- Head outputs are registered and stable while `evt_valid && !evt_ready`.
- Reset asserted mid-operation flushes the stage register and FIFO immediately.

## Configuration
- `COLLISION_DROP_CNT_EN` defined: adds output `drop_cnt` (8 bits). It increments once per dropped event, saturates at 255, and resets to 0.
- Macro undefined: no port, no counter, and drops are silent.

## Structure
- `collision_pkg` holds:
  - `evt_type_t` enum (NONE=00, WALL=01, HOLE=10, BALL=11).
  - Wall code constants.
  - The `event_t` struct {type, id_a, id_b, info}.
- Sub-module `event_fifo` is parametrised on width and depth, with showahead and full/empty flags.
- Lowest- and second-lowest-bit selection are functions in the package.

## Test plan
- Reset, then `Balls_DR_VEC`=0x0003 for 1 cycle → after 2 cycles one BALL event with a=0, b=1. Repeat in the same frame → no new event. After 2 `startOfFrame` pulses, repeat → new event.
- `Table_DR`=10 with ball 5 for 10 consecutive cycles → exactly one WALL event with a=5, info=2.
- `Hole_DR`, `Hole_ID`=3, ball 7 → HOLE event with a=7, info=3, and `balls_in_game[7]`=0. Later ball-7 overlaps produce nothing and `collision`=0.
- Same cycle: hole on ball 2 and balls {2,4} overlapping → HOLE event only, and ball 2 removed. The next cycle produces no BALL event, since ball 2 is out of game.
- `evt_ready`=0, then generate 10 distinct wall events → 8 stored. With the macro enabled, `drop_cnt`=2. Draining yields the first 8 in order.
- Balls {1,3,6} overlapping → BALL event with a=1, b=3 only.
